svc_rv_mem_arbiter: RTL and testbench
=====================================

Name: svc_rv_mem_arbiter

Overview:
- Shares one synchronous read port between instruction fetch (I) and data load (D) requesters; sits between the IF/MEM stages and the single memory read channel.
- Arbitrates address requests with D priority and an I anti-starvation counter.
- Tracks ownership of up to DEPTH in-order outstanding reads and routes each response back to its owner.
- Discards in-flight fetch responses on a pipeline flush.

Parameters:
- DEPTH, 4, max outstanding reads; power of 2, >=2.
- STARVE_MAX, 4, consecutive D grants while I waits before I is forced a grant; >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_arvalid  in  1  fetch request valid
- i_arready  out  1  fetch request accepted
- i_araddr  in  32  fetch address
- i_rvalid  out  1  fetch response valid
- i_rdata  out  32  fetch response data
- i_flush  in  1  discard all fetch responses outstanding before this edge
- d_arvalid  in  1  load request valid
- d_arready  out  1  load request accepted
- d_araddr  in  32  load address
- d_rvalid  out  1  load response valid
- d_rdata  out  32  load response data
- m_arvalid  out  1  memory request valid
- m_arready  in  1  memory accepts request
- m_araddr  out  32  memory address
- m_rvalid  in  1  memory response valid, in request order
- m_rdata  in  32  memory response data
- outstanding  out  $clog2(DEPTH+1)  reads in flight
- err  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync-released use): owner FIFO empty, outstanding=0, starve_cnt=0, err=0. Outputs i_rvalid, d_rvalid, m_arvalid, i_arready, d_arready all 0.
- Reset mid-operation drops all tracking. Responses arriving after release with an empty FIFO set err.
- full = (outstanding==DEPTH). A pop in the same cycle does not relieve full; requests are blocked that cycle.
- Select (combinational):
  - sel_d = d_arvalid && (!i_arvalid || starve_cnt<STARVE_MAX); otherwise sel_i = i_arvalid.
- m_arvalid = (i_arvalid||d_arvalid) && !full.
- m_araddr = sel_d ? d_araddr : i_araddr.
- d_arready = sel_d && !full && m_arready; i_arready = sel_i && !full && m_arready.
- No ready-to-valid combinational loop from the requester side; arready depends on m_arready.
- Accept (m_arvalid && m_arready): push entry {owner, discard=0} to the owner FIFO.
- starve_cnt, updated on accept only:
  - D granted while i_arvalid: saturating increment.
  - I granted: clear.
  - Any cycle with !i_arvalid: clear.
- Response: m_rvalid pops the head; zero added latency, combinational routing.
  - owner=D: d_rvalid=1.
  - owner=I: i_rvalid = !discard && !i_flush.
- i_rdata = d_rdata = m_rdata unconditionally; data is valid only with the matching rvalid.
- i_flush at an edge sets discard on every owner=I entry resident before that edge. The entry popped that cycle is also suppressed.
- An I request accepted in the flush cycle is NOT discarded; it is the redirected fetch.
- D entries are never discarded.
- m_rvalid with an empty FIFO: no pop, no rvalid out, err<=1 until reset.
- Push and pop in the same cycle: outstanding unchanged; pointers both advance (wrap mod DEPTH).
- outstanding is registered and equals the FIFO count.

Test Plan:
- Reset, then an I request to 0x100, m_arready=1, m_rvalid next cycle with 0x00000013 -> i_arready=1 in cycle 0, i_rvalid=1, i_rdata=0x13 in cycle 1, outstanding back to 0.
- I and D both valid every cycle, m_arready=1, STARVE_MAX=4 -> grant pattern D,D,D,D,I repeating; starve_cnt returns to 0 after each I grant.
- Issue I@0x0, D@0x200, I@0x4, then responses A,B,C -> i_rvalid(A), d_rvalid(B), i_rvalid(C) in order.
- Issue 4 reads with no response (DEPTH=4) -> outstanding=4, arready=0 for both. Issue a response plus a new request in the same cycle -> request blocked that cycle, accepted the next.
- Two I reads outstanding, then i_flush with a new I request the same cycle -> the two old responses produce no i_rvalid; the new request's response asserts i_rvalid.
- m_rvalid with outstanding=0 -> err=1, no rvalid out. Async rst_n low mid-transfer -> err=0, outstanding=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/svc_rv_mem_arbiter.sv
// svc_rv_mem_arbiter
// Shares one in-order memory read channel between instruction fetch (I) and
// data load (D). Load requests have priority. A starvation counter forces an
// I grant after STARVE_MAX consecutive D grants while I is waiting. A small
// owner FIFO records who issued each outstanding read, so that every in-order
// response is routed back to its owner. A pipeline flush discards the fetch
// responses that are still in flight.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_arvalid/i_arready/i_araddr     fetch request channel
//   i_rvalid/i_rdata                 fetch response channel
//   i_flush                          discard fetch responses in flight
//   d_arvalid/d_arready/d_araddr     load request channel
//   d_rvalid/d_rdata                 load response channel
//   m_arvalid/m_arready/m_araddr     shared memory request channel
//   m_rvalid/m_rdata                 shared memory response channel (in order)
//   outstanding                      number of reads in flight (registered)
//   err                              sticky: response arrived with none in flight
module svc_rv_mem_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_arvalid,
    output logic                         i_arready,
    input  logic [31:0]                  i_araddr,
    output logic                         i_rvalid,
    output logic [31:0]                  i_rdata,
    input  logic                         i_flush,
    input  logic                         d_arvalid,
    output logic                         d_arready,
    input  logic [31:0]                  d_araddr,
    output logic                         d_rvalid,
    output logic [31:0]                  d_rdata,
    output logic                         m_arvalid,
    input  logic                         m_arready,
    output logic [31:0]                  m_araddr,
    input  logic                         m_rvalid,
    input  logic [31:0]                  m_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    // One owner-FIFO slot: who issued the read and whether its data is dropped
    typedef struct packed {
        logic owner_d;
        logic discard;
    } owner_entry_t;

    owner_entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [STV_W-1:0]       starve_q;

    logic                   full_c;
    logic                   empty_c;
    logic                   sel_d_c;
    logic                   sel_i_c;
    logic                   push_c;
    logic                   pop_c;
    owner_entry_t           head_c;

    // Arbitration, request routing and response routing
    always_comb begin
        full_c    = (outstanding == CNT_W'(DEPTH));
        empty_c   = (outstanding == CNT_W'(0));
        sel_d_c   = d_arvalid && (!i_arvalid || (starve_q < STV_W'(STARVE_MAX)));
        sel_i_c   = !sel_d_c && i_arvalid;

        m_arvalid = (i_arvalid || d_arvalid) && !full_c;
        m_araddr  = sel_d_c ? d_araddr : i_araddr;
        d_arready = sel_d_c && !full_c && m_arready;
        i_arready = sel_i_c && !full_c && m_arready;
        push_c    = m_arvalid && m_arready;

        // A response with nothing in flight is an error, never a pop
        pop_c     = m_rvalid && !empty_c;
        head_c    = fifo_q[rd_ptr_q];
        d_rvalid  = pop_c && head_c.owner_d;
        // A flush in the pop cycle also suppresses the fetch being returned
        i_rvalid  = pop_c && !head_c.owner_d && !head_c.discard && !i_flush;

        i_rdata   = m_rdata;
        d_rdata   = m_rdata;
    end

    // Owner FIFO storage; flush marks every fetch slot, a push rewrites its slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                fifo_q[PTR_W'(k)] <= '0;
            end
        end else begin
            if (i_flush) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if (!fifo_q[PTR_W'(k)].owner_d) begin
                        fifo_q[PTR_W'(k)].discard <= 1'b1;
                    end
                end
            end
            // Later assignment wins: a fetch accepted in the flush cycle survives
            if (push_c) begin
                fifo_q[wr_ptr_q] <= '{owner_d: sel_d_c, discard: 1'b0};
            end
        end
    end

    // Pointers, occupancy and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!push_c && pop_c) begin
                outstanding <= outstanding - CNT_W'(1);
            end
            if (m_rvalid && empty_c) begin
                err <= 1'b1;
            end
        end
    end

    // Starvation counter: counts D grants that bypassed a waiting fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!i_arvalid) begin
            starve_q <= '0;
        end else if (push_c) begin
            if (sel_i_c) begin
                starve_q <= '0;
            end else if (starve_q != STV_W'(STARVE_MAX)) begin
                starve_q <= starve_q + STV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_svc_rv_mem_arbiter.sv
// Scoreboard bench for svc_rv_mem_arbiter (DEPTH=4, STARVE_MAX=4).
// Each accepted request pushes its expected response (owner, discard, data);
// each memory response pops it and checks routing and data.
module tb_svc_rv_mem_arbiter;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_arvalid, i_arready, i_rvalid, i_flush;
    logic [31:0] i_araddr, i_rdata;
    logic        d_arvalid, d_arready, d_rvalid;
    logic [31:0] d_araddr, d_rdata;
    logic        m_arvalid, m_arready, m_rvalid;
    logic [31:0] m_araddr, m_rdata;
    logic [2:0]  outstanding;
    logic        err;

    svc_rv_mem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_flush(i_flush),
        .d_arvalid(d_arvalid), .d_arready(d_arready), .d_araddr(d_araddr),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          disc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt = 0;
    int   m_starve = 0;
    bit   m_err = 1'b0;
    int   dut_grant;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a - 32'h0000_00ED;   // 0x100 -> 0x13
    endfunction

    // One clock of stimulus: drive at negedge, check combinational outputs,
    // advance the model and check registered outputs after the edge.
    task automatic cycle(input bit iv, input logic [31:0] ia, input bit dv,
                         input logic [31:0] da, input bit mar, input bit mrv,
                         input bit fl);
        bit   full, sel_d, sel_i, exp_mav, exp_ir, exp_dr, pop, accept;
        exp_t head;
        exp_t ne;
        @(negedge clk);
        i_arvalid = iv; i_araddr = ia; d_arvalid = dv; d_araddr = da;
        m_arready = mar; m_rvalid = mrv; i_flush = fl;
        m_rdata   = (mrv && sb.size() > 0) ? sb[0].data : 32'hDEAD_BEEF;
        #1;
        full    = (m_cnt == DEPTH);
        sel_d   = dv && (!iv || m_starve < STARVE_MAX);
        sel_i   = !sel_d && iv;
        exp_mav = (iv || dv) && !full;
        exp_ir  = sel_i && !full && mar;
        exp_dr  = sel_d && !full && mar;
        accept  = exp_mav && mar;
        chk("m_arvalid", 32'(m_arvalid), 32'(exp_mav));
        chk("i_arready", 32'(i_arready), 32'(exp_ir));
        chk("d_arready", 32'(d_arready), 32'(exp_dr));
        if (exp_mav) chk("m_araddr", m_araddr, sel_d ? da : ia);
        dut_grant = i_arready ? 1 : (d_arready ? 2 : 0);
        pop = mrv && sb.size() > 0;
        if (pop) begin
            head = sb[0];
            chk("i_rvalid", 32'(i_rvalid), 32'(!head.is_d && !head.disc && !fl));
            chk("d_rvalid", 32'(d_rvalid), 32'(head.is_d));
            chk(head.is_d ? "d_rdata" : "i_rdata", head.is_d ? d_rdata : i_rdata, head.data);
        end else begin
            chk("i_rvalid_idle", 32'(i_rvalid), 32'd0);
            chk("d_rvalid_idle", 32'(d_rvalid), 32'd0);
        end
        // model update: flush marks resident fetches, then pop, then push
        if (fl) foreach (sb[k]) if (!sb[k].is_d) sb[k].disc = 1'b1;
        if (pop) void'(sb.pop_front());
        if (mrv && !pop) m_err = 1'b1;
        if (accept) begin
            ne.is_d = sel_d; ne.disc = 1'b0; ne.data = rdata_of(sel_d ? da : ia);
            sb.push_back(ne);
        end
        m_cnt = m_cnt + (accept ? 1 : 0) - (pop ? 1 : 0);
        if (!iv) m_starve = 0;
        else if (accept) m_starve = sel_i ? 0 : (m_starve < STARVE_MAX ? m_starve + 1 : m_starve);
        @(posedge clk); #1;
        chk("outstanding", 32'(outstanding), 32'(m_cnt));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic idle_inputs();
        i_arvalid = 0; i_araddr = '0; d_arvalid = 0; d_araddr = '0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; i_flush = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 16 && sb.size() > 0; n++) cycle(0, 0, 0, 0, 0, 1, 0);
        chk("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #23;
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_outs", {27'd0, i_rvalid, d_rvalid, m_arvalid, i_arready, d_arready}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // single fetch, response next cycle
        cycle(1, 32'h100, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        chk("t1_outstanding", 32'(outstanding), 32'd0);

        // contention: D,D,D,D,I repeating; respond each cycle to stay shallow
        for (int k = 0; k < 10; k++) begin
            cycle(1, 32'h1000 + 32'(k * 4), 1, 32'h2000 + 32'(k * 4), 1, sb.size() > 0, 0);
            chk("grant_pattern", 32'(dut_grant), (k % 5 == 4) ? 32'd1 : 32'd2);
        end
        drain();

        // mixed ordering I, D, I
        cycle(1, 32'h0, 0, 0, 1, 0, 0);
        cycle(0, 0, 1, 32'h200, 1, 0, 0);
        cycle(1, 32'h4, 0, 0, 1, 0, 0);
        drain();

        // fill to DEPTH; response plus request same cycle is blocked
        for (int k = 0; k < 4; k++) cycle(k[0], 32'h300 + 32'(k * 4), !k[0], 32'h400 + 32'(k * 4), 1, 0, 0);
        chk("full_outstanding", 32'(outstanding), 32'd4);
        cycle(1, 32'h500, 0, 0, 1, 1, 0);
        chk("full_block_grant", 32'(dut_grant), 32'd0);
        cycle(1, 32'h504, 0, 0, 1, 0, 0);
        chk("after_full_grant", 32'(dut_grant), 32'd1);
        drain();

        // flush with redirected fetch in the same cycle
        cycle(1, 32'h600, 0, 0, 1, 0, 0);
        cycle(1, 32'h604, 0, 0, 1, 0, 0);
        cycle(1, 32'h800, 0, 0, 1, 0, 1);
        drain();

        // flush coinciding with a pop, plus a D entry that must survive
        cycle(1, 32'h900, 0, 0, 1, 0, 0);
        cycle(0, 0, 1, 32'hA00, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        drain();

        // response with nothing outstanding
        cycle(0, 0, 0, 0, 0, 1, 0);
        chk("err_set", 32'(err), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // async reset mid-transfer, between clock edges
        cycle(1, 32'hB00, 0, 0, 1, 0, 0);
        @(negedge clk); idle_inputs(); #2;
        rst_n = 1'b0;
        #1;
        chk("async_outstanding", 32'(outstanding), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        sb.delete(); m_cnt = 0; m_starve = 0; m_err = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 1, 0);
        chk("post_reset_err", 32'(err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
